// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg -- shared types and constants for the pattern transmitter.
//   state_t          : transmitter FSM states (idle, sending bits, inter-repetition gap, done pulse)
//   DEFAULT_PATTERN  : the 1011 pattern recognised by the team's sequence detector
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if -- request/stream bundle between a requester and pattern_tx.
//   start, abort     : transfer request / synchronous cancel
//   pat_in, rep_in   : pattern (MSB first) and repetition count, sampled on acceptance
//   ready            : transmitter idle, start will be accepted
//   x_out, x_valid   : serial bit stream and its qualifier
//   done             : one-cycle end-of-transfer pulse
// master drives the request side, slave is the transmitter.
interface pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [REP_W-1:0] rep_in;
  logic             ready;
  logic             x_out;
  logic             x_valid;
  logic             done;

  modport master (
    output start, abort, pat_in, rep_in,
    input  ready, x_out, x_valid, done
  );

  modport slave (
    input  start, abort, pat_in, rep_in,
    output ready, x_out, x_valid, done
  );
endinterface

// File: rtl/pattern_shreg.sv
// pattern_shreg -- PAT_W-bit parallel-load shift register, MSB first, with bit counter.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture pat_in, restart the bit counter (has priority over shift)
//   shift      : advance to the next bit
//   pat_in     : pattern to load
//   msb        : bit currently presented
//   last_bit   : msb is bit 0 of the loaded pattern
// The register rotates rather than shifting in zeros, so after PAT_W shifts it
// holds the original pattern again; this lets the next repetition start with no
// reload cycle.
module pattern_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat_in,
  output logic             msb,
  output logic             last_bit
);
  localparam int CNT_W = $clog2(PAT_W);

  logic [PAT_W-1:0] data;
  logic [CNT_W-1:0] bit_cnt;

  // NOTE: state is updated with <= so every flop samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  // NOTE: data is a flop register, not a memory array, so it takes the async
  // reset like every other state bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      data    <= pat_in;
      bit_cnt <= '0;
    end else if (shift) begin
      data    <= {data[PAT_W-2:0], data[PAT_W-1]};
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  assign msb      = data[PAT_W-1];
  assign last_bit = (bit_cnt == CNT_W'(PAT_W - 1));
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx -- serial pattern transmitter.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : pattern_tx_if.slave (start/abort/pat_in/rep_in in, ready/x_out/x_valid/done out)
// On an accepted start the pattern is sent MSB first, max(rep_in,1) times, with
// GAP idle cycles between repetitions, followed by a one-cycle done pulse.
// All outputs are decoded from registered state, so reset clears them at once.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input logic        clk,
  input logic        reset,
  pattern_tx_if.slave bus
);
  // Terminal count of the gap counter; unused when GAP is 0.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             shift;
  logic             msb;
  logic             last_bit;
  logic             more_reps;
  logic [REP_W-1:0] rep_left;
  logic [3:0]       gap_cnt;

  pattern_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .pat_in   (bus.pat_in),
    .msb      (msb),
    .last_bit (last_bit)
  );

  // rep_left counts the repetition in flight plus those still to come; it is
  // loaded with at least 1, so it never needs to count past rep_in.
  assign more_reps = (rep_left > REP_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_left <= '0;
      gap_cnt  <= '0;
    end else begin
      if (load)
        rep_left <= (bus.rep_in == '0) ? REP_W'(1) : bus.rep_in;
      else if (state == ST_SEND && last_bit)
        rep_left <= rep_left - REP_W'(1);
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // abort beats a simultaneous start
        if (bus.start && !bus.abort) begin
          next_state = ST_SEND;
          load       = 1'b1;
        end
      end
      ST_SEND: begin
        shift = 1'b1;
        if (bus.abort)
          next_state = ST_IDLE;
        else if (last_bit) begin
          if (!more_reps)   next_state = ST_DONE;
          else if (GAP > 0) next_state = ST_GAP;
          else              next_state = ST_SEND;
        end
      end
      ST_GAP: begin
        if (bus.abort)                 next_state = ST_IDLE;
        else if (gap_cnt == GAP_LAST)  next_state = ST_SEND;
      end
      ST_DONE: next_state = ST_IDLE;  // abort deliberately ignored here
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.ready   = (state == ST_IDLE);
  assign bus.x_valid = (state == ST_SEND);
  assign bus.x_out   = (state == ST_SEND) && msb;
  assign bus.done    = (state == ST_DONE);
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx -- self-checking bench for pattern_tx.
// Two instances (GAP=0 and GAP=2) share clock, reset and stimulus. A schedule
// model expands each accepted request into the per-cycle output sequence it
// must produce; every cycle both instances are compared with it.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  localparam int PAT_W = 4;
  localparam int REP_W = 4;
  localparam logic [3:0] PB = DEFAULT_PATTERN;

  // expected outputs packed as {ready, x_valid, x_out, done}
  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] pat;
    logic [3:0] rep;
    logic [3:0] exp;
  } vec_t;

  typedef logic [2:0] ent_t;  // {x_valid, x_out, done}

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) if0 ();
  pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) if2 ();

  pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  int errors = 0;
  int checks = 0;

  // reference schedule per instance
  ent_t sched [2][256];
  int   len [2];
  int   pos [2];
  int   gap_of [2] = '{0, 2};

  // observation counters (dut index 0 = GAP 0, 1 = GAP 2)
  int         cyc;
  int         det_cnt, done_cnt, valid_cnt;
  int         done_cyc0, done_cyc2;
  logic [3:0] win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_out(input int d);
    if (d == 0) return {if0.ready, if0.x_valid, if0.x_out, if0.done};
    return {if2.ready, if2.x_valid, if2.x_out, if2.done};
  endfunction

  function automatic logic [3:0] model_out(input int d);
    if (pos[d] >= len[d]) return 4'b1000;
    return {1'b0, sched[d][pos[d]]};
  endfunction

  task automatic build(input int d, input logic [3:0] pat, input logic [3:0] rep);
    int reps;
    reps = (rep == 4'd0) ? 1 : int'(rep);
    len[d] = 0;
    pos[d] = 0;
    for (int r = 0; r < reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        sched[d][len[d]] = {1'b1, pat[b], 1'b0};
        len[d]++;
      end
      if (r < reps - 1)
        for (int g = 0; g < gap_of[d]; g++) begin
          sched[d][len[d]] = 3'b000;
          len[d]++;
        end
    end
    sched[d][len[d]] = 3'b001;
    len[d]++;
  endtask

  // advance the model across one rising edge, given the inputs seen there
  task automatic model_edge(input int d, input logic st, input logic ab,
                            input logic [3:0] pat, input logic [3:0] rep);
    if (pos[d] >= len[d]) begin
      if (st && !ab) build(d, pat, rep);
    end else if (ab && sched[d][pos[d]] != 3'b001) begin
      len[d] = 0;
      pos[d] = 0;
    end else begin
      pos[d]++;
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic [3:0] pat, input logic [3:0] rep);
    if0.start = st; if0.abort = ab; if0.pat_in = pat; if0.rep_in = rep;
    if2.start = st; if2.abort = ab; if2.pat_in = pat; if2.rep_in = rep;
  endtask

  task automatic clear_obs();
    cyc = 0; det_cnt = 0; done_cnt = 0; valid_cnt = 0;
    done_cyc0 = -1; done_cyc2 = -1; win = 4'b0000;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    len = '{0, 0};
    pos = '{0, 0};
    clear_obs();
  endtask

  // one clock cycle: drive at the falling edge, compare, cross the rising edge
  task automatic cycle(input logic st, input logic ab, input logic [3:0] pat, input logic [3:0] rep);
    drive(st, ab, pat, rep);
    check($sformatf("gap0 cyc%0d", cyc), 32'(dut_out(0)), 32'(model_out(0)));
    check($sformatf("gap2 cyc%0d", cyc), 32'(dut_out(1)), 32'(model_out(1)));
    win = {win[2:0], if0.x_out};
    if (win == 4'b1011) det_cnt++;
    if (if0.done) done_cnt++;
    if (if0.x_valid) valid_cnt++;
    if (if0.done && done_cyc0 < 0) done_cyc0 = cyc;
    if (if2.done && done_cyc2 < 0) done_cyc2 = cyc;
    @(posedge clk);
    model_edge(0, st, ab, pat, rep);
    model_edge(1, st, ab, pat, rep);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    logic st, ab;

    do_reset();
    check("reset gap0", 32'(dut_out(0)), 32'h8);
    check("reset gap2", 32'(dut_out(1)), 32'h8);

    // basic transfer, abort+start in idle, input changes mid-transfer, abort in done
    tbl[0]  = '{1'b1, 1'b0, PB,    4'd1,  4'b1000};
    tbl[1]  = '{1'b0, 1'b0, PB,    4'd1,  4'b0110};
    tbl[2]  = '{1'b0, 1'b0, PB,    4'd1,  4'b0100};
    tbl[3]  = '{1'b0, 1'b0, PB,    4'd1,  4'b0110};
    tbl[4]  = '{1'b0, 1'b0, PB,    4'd1,  4'b0110};
    tbl[5]  = '{1'b0, 1'b0, PB,    4'd1,  4'b0001};
    tbl[6]  = '{1'b1, 1'b1, PB,    4'd1,  4'b1000};
    tbl[7]  = '{1'b0, 1'b0, PB,    4'd1,  4'b1000};
    tbl[8]  = '{1'b1, 1'b0, 4'hC,  4'd1,  4'b1000};
    tbl[9]  = '{1'b0, 1'b0, 4'h3,  4'd15, 4'b0110};
    tbl[10] = '{1'b1, 1'b0, 4'h0,  4'd15, 4'b0110};
    tbl[11] = '{1'b0, 1'b0, 4'hF,  4'd0,  4'b0100};
    tbl[12] = '{1'b0, 1'b0, 4'hF,  4'd0,  4'b0100};
    tbl[13] = '{1'b0, 1'b1, 4'hF,  4'd0,  4'b0001};
    tbl[14] = '{1'b0, 1'b0, 4'hF,  4'd0,  4'b1000};
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].pat, tbl[i].rep);
      check($sformatf("vec%0d", i), 32'(dut_out(0)), 32'(tbl[i].exp));
      @(posedge clk);
      @(negedge clk);
    end

    // three back-to-back repetitions into a 1011 detector
    do_reset();
    cycle(1'b1, 1'b0, PB, 4'd3);
    repeat (14) cycle(1'b0, 1'b0, PB, 4'd3);
    check("rep3 detect count", 32'(det_cnt), 32'd3);
    check("rep3 done cycle", 32'(done_cyc0), 32'd13);

    // two repetitions separated by a 2-cycle gap
    do_reset();
    cycle(1'b1, 1'b0, PB, 4'd2);
    repeat (12) cycle(1'b0, 1'b0, PB, 4'd2);
    check("gap2 done cycle", 32'(done_cyc2), 32'd11);

    // abort at cycle 2 with a competing start
    do_reset();
    cycle(1'b1, 1'b0, PB, 4'd1);
    cycle(1'b0, 1'b0, PB, 4'd1);
    cycle(1'b1, 1'b1, PB, 4'd1);
    check("abort ready", 32'(if0.ready), 32'd1);
    check("abort x_valid", 32'(if0.x_valid), 32'd0);
    repeat (6) cycle(1'b0, 1'b0, PB, 4'd1);
    check("abort no done", 32'(done_cnt), 32'd0);

    // asynchronous reset in the middle of SEND
    do_reset();
    repeat (3) cycle(cyc == 0, 1'b0, PB, 4'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset gap0", 32'(dut_out(0)), 32'h8);
    check("async reset gap2", 32'(dut_out(1)), 32'h8);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    len = '{0, 0};
    pos = '{0, 0};
    clear_obs();
    cycle(1'b1, 1'b0, PB, 4'd0);
    repeat (8) cycle(1'b0, 1'b0, PB, 4'd0);
    check("rep0 valid cycles", 32'(valid_cnt), 32'd4);
    check("rep0 detect count", 32'(det_cnt), 32'd1);
    check("rep0 done count", 32'(done_cnt), 32'd1);

    // start held high: back-to-back transfers, one idle cycle between
    do_reset();
    repeat (13) cycle(1'b1, 1'b0, PB, 4'd1);
    check("held start done count", 32'(done_cnt), 32'd2);
    check("held start valid cycles", 32'(valid_cnt), 32'd8);

    // maximum repetition count must not wrap
    do_reset();
    cycle(1'b1, 1'b0, 4'h9, 4'd15);
    repeat (70) cycle(1'b0, 1'b0, 4'h9, 4'd15);
    check("rep15 valid cycles", 32'(valid_cnt), 32'd60);
    check("rep15 done cycle", 32'(done_cyc0), 32'd61);

    // randomized traffic against the schedule model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 19) == 0);
      cycle(st, ab, 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, 2..16.
REQ-002 Parameter REP_W, default 4: width of the repetition-count input.
REQ-003 Parameter GAP, default 0: idle cycles (x_out=0) inserted between repetitions, 0..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  request to transmit; accepted only when start=1 and ready=1 on a rising edge.
REQ-007 abort  input  1  synchronous cancel of a transfer in progress.
REQ-008 pat_in  input  PAT_W  pattern to send, MSB first; sampled at acceptance only.
REQ-009 rep_in  input  REP_W  number of pattern repetitions; sampled at acceptance; 0 is treated as 1.
REQ-010 ready  output  1  1 only in IDLE.
REQ-011 x_out  output  1  serial bit stream; compatible with the team's 1011 sequence detector x input.
REQ-012 x_valid  output  1  1 while x_out carries a pattern bit.
REQ-013 done  output  1  one-cycle pulse after the last bit of the last repetition.

Function
REQ-014 The FSM SHALL have the states IDLE, SEND, GAP and DONE.
REQ-015 IDLE->SEND on accepted start; the first bit, pat_in[PAT_W-1], appears on x_out in the cycle after acceptance (latency 1).
REQ-016 SEND: one bit per cycle, MSB first; after bit 0, go to GAP if repetitions remain and GAP>0, to SEND (reloaded pattern, no bubble) if repetitions remain and GAP=0, otherwise to DONE.
REQ-017 GAP: exactly GAP cycles with x_out=0 and x_valid=0, then SEND.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 x_out SHALL be 0 whenever x_valid=0.
REQ-020 Total x_valid cycles per transfer SHALL equal PAT_W*max(rep_in,1); the repetition counter SHALL NOT wrap for rep_in=2^REP_W-1.
REQ-021 start while ready=0 SHALL be ignored, with no queuing; pat_in and rep_in changes during a transfer SHALL have no effect.
REQ-022 abort=1 in SEND or GAP: next state IDLE, x_valid=0, x_out=0, and no done pulse.
REQ-023 abort and start both high in IDLE: abort wins and the start is not accepted.
REQ-024 abort in DONE SHALL be ignored, so done still pulses.

Reset
REQ-025 While reset=0: state IDLE; ready=1; x_out=0, x_valid=0, done=0; shift register and counters cleared. Effect is asynchronous, including mid-transfer.
REQ-026 After deassertion, the first accepted start SHALL behave exactly as from power-up.

Structure
REQ-027 The shared package SHALL hold the state enum (IDLE/SEND/GAP/DONE) and the constant DEFAULT_PATTERN = 4'b1011.
REQ-028 A single sub-module, pattern_shreg, SHALL implement the PAT_W-bit parallel-load, MSB-first shift register with bit counter and last_bit flag; all other logic SHALL be in pattern_tx.

Verification
REQ-029 Defaults, pat_in=1011, rep_in=1, start pulse at cycle 0 -> x_out 1,0,1,1 with x_valid=1 on cycles 1-4, done=1 on cycle 5, ready=1 on cycle 6.
REQ-030 rep_in=3, GAP=0, x_out fed to the 1011 detector -> stream 101110111011, detect asserted exactly 3 times, done on cycle 13.
REQ-031 GAP=2, rep_in=2 -> bits 1011, then 00 with x_valid=0, then 1011; done on cycle 11.
REQ-032 abort at cycle 2 of a rep_in=1 transfer -> x_valid=0 from cycle 3, no done, ready=1 at cycle 3; a second start in the same cycle as abort is not accepted.
REQ-033 reset=0 asserted mid-SEND, asynchronously between edges -> outputs return to reset values immediately; after release, a start with rep_in=0 sends 1011 exactly once.
REQ-034 start held high continuously, rep_in=1 -> back-to-back transfers: 4 bits, done, one IDLE cycle, repeat; intervening start pulses are never lost or doubled.
